// File: rtl/fifo_pkg.sv
// Shared widths, derived depth and default thresholds for the FIFO pointer stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_pkg;

  // Default address width; the FIFO holds 2^W entries.
  localparam int FIFO_W_ADDRESS = 4;
  localparam int FIFO_DEPTH     = 1 << FIFO_W_ADDRESS;

  // Default almost-full / almost-empty thresholds, in entries.
  localparam int FIFO_AF_TH = 12;
  localparam int FIFO_AE_TH = 4;

  // Pointer carries one extra wrap bit above the RAM address.
  typedef logic [FIFO_W_ADDRESS:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/ptr_counter.sv
// Wrapping binary pointer counter with advance enable and synchronous clear.
// Latency: one cycle, the value updates on the edge where en/clr is sampled.
// Backpressure: none; the caller gates en.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear, overrides en
//   en   - advance by one, wraps modulo 2^W
//   q    - current pointer value
module ptr_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule : ptr_counter

// File: rtl/fifo_pointer_gen.sv
// FIFO read/write pointer generation with occupancy count and almost-full/empty flags.
// Latency: one cycle from enable to pointers, addresses, count and flags.
// Backpressure: none upstream; write ignored when full, read ignored when empty.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - synchronous clear to reset state (below rst, above enables)
//   rd_en_ptr        - gated read advance from the controller
//   wr_en_ptr        - gated write advance from the controller
//   read_pointer     - read pointer, MSB is the wrap bit
//   write_pointer    - write pointer, MSB is the wrap bit
//   rd_addr/wr_addr  - RAM addresses (pointers without the wrap bit)
//   count            - registered occupancy, 0..DEPTH
//   ALMOST_FULL      - registered, count >= AF_TH
//   ALMOST_EMPTY     - registered, count <= AE_TH
module fifo_pointer_gen
  import fifo_pkg::*;
#(
  parameter int W_ADDRESS = FIFO_W_ADDRESS,
  parameter int AF_TH     = FIFO_AF_TH,
  parameter int AE_TH     = FIFO_AE_TH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 rd_en_ptr,
  input  logic                 wr_en_ptr,
  output logic [W_ADDRESS:0]   read_pointer,
  output logic [W_ADDRESS:0]   write_pointer,
  output logic [W_ADDRESS-1:0] rd_addr,
  output logic [W_ADDRESS-1:0] wr_addr,
  output logic [W_ADDRESS:0]   count,
  output logic                 ALMOST_FULL,
  output logic                 ALMOST_EMPTY
);

  localparam int DEPTH = 1 << W_ADDRESS;
  localparam logic [W_ADDRESS:0] DEPTH_C = (W_ADDRESS+1)'(DEPTH);
  localparam logic [W_ADDRESS:0] AF_C    = (W_ADDRESS+1)'(AF_TH);
  localparam logic [W_ADDRESS:0] AE_C    = (W_ADDRESS+1)'(AE_TH);

  generate
    if (!(AE_TH >= 0 && AE_TH < AF_TH && AF_TH <= DEPTH)) begin : g_bad_thresholds
      $error("fifo_pointer_gen: thresholds must satisfy 0 <= AE_TH < AF_TH <= DEPTH");
    end
  endgenerate

  logic               wr_eff;
  logic               rd_eff;
  logic [W_ADDRESS:0] count_nxt;

  // Defensive gating: a write into a full FIFO or a read from an empty one
  // would break the pointer/count relationship, so they are dropped here.
  assign wr_eff = wr_en_ptr && (count != DEPTH_C);
  assign rd_eff = rd_en_ptr && (count != '0);

  ptr_counter #(.W(W_ADDRESS + 1)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (rd_eff),
    .q   (read_pointer)
  );

  ptr_counter #(.W(W_ADDRESS + 1)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (wr_eff),
    .q   (write_pointer)
  );

  assign rd_addr = read_pointer[W_ADDRESS-1:0];
  assign wr_addr = write_pointer[W_ADDRESS-1:0];

  // Next-state count; flags are derived from it so they land on the same
  // edge as the count they describe.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_eff && !rd_eff) begin
      count_nxt = count + (W_ADDRESS+1)'(1);
    end else if (rd_eff && !wr_eff) begin
      count_nxt = count - (W_ADDRESS+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      count        <= count_nxt;
      ALMOST_FULL  <= (count_nxt >= AF_C);
      ALMOST_EMPTY <= (count_nxt <= AE_C);
    end
  end

endmodule : fifo_pointer_gen
